reg_writeback: RTL

Writeback stage sitting directly in front of the 32x32 register file write port (`write_reg`, `write_data`, `regwrite`). It merges single-cycle ALU results with long-latency load/store-unit (LSU) results into exactly one register-file write per cycle, buffering LSU results in a small FIFO. It also keeps a destination-register scoreboard so decode can stall on operands whose long-latency producer has not yet written back.

---
 rtl/reg_writeback_if.sv | 36 +++
 rtl/reg_writeback.sv | 81 ++++++++
 2 files changed

// File: rtl/reg_writeback_if.sv
// reg_writeback_if: ALU/LSU result, reservation, operand-check and register-file write signals
interface reg_writeback_if;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_stall;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        rsv_valid;
   logic [4:0]  rsv_rd;
   logic [4:0]  chk_rs1;
   logic [4:0]  chk_rs2;
   logic        busy_rs1;
   logic        busy_rs2;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic        regwrite;
   logic [31:0] pending;
   logic        sb_err;

   modport master (
      output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
             rsv_valid, rsv_rd, chk_rs1, chk_rs2,
      input  alu_stall, lsu_ready, busy_rs1, busy_rs2, write_reg, write_data,
             regwrite, pending, sb_err
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
             rsv_valid, rsv_rd, chk_rs1, chk_rs2,
      output alu_stall, lsu_ready, busy_rs1, busy_rs2, write_reg, write_data,
             regwrite, pending, sb_err
   );
endinterface

// File: rtl/reg_writeback.sv
// reg_writeback: merges ALU and buffered LSU results into one register-file write per cycle, with a pending scoreboard
module reg_writeback #(
   parameter int LSU_DEPTH = 2
) (
   input logic           clock,
   input logic           reset,
   reg_writeback_if.slave bus
);
   localparam int PW = $clog2(LSU_DEPTH);

   logic [4:0]    fifo_rd   [LSU_DEPTH];
   logic [31:0]   fifo_data [LSU_DEPTH];
   logic [PW-1:0] head, tail;
   logic [2:0]    count;
   logic          full, empty, push, pop, sel_alu, sel, wb_lsu, clr, set_rsv, err;
   logic [4:0]    sel_rd;
   logic [31:0]   sel_data, set_mask, clr_mask;

   assign full          = count == 3'(LSU_DEPTH);
   assign empty         = count == 3'd0;
   assign bus.lsu_ready = reset && !full;
   assign bus.alu_stall = full;
   assign push          = bus.lsu_valid && bus.lsu_ready;
   assign sel_alu       = !full && bus.alu_valid;
   assign pop           = !sel_alu && !empty;
   assign sel           = sel_alu || pop;
   assign sel_rd        = sel_alu ? bus.alu_rd : fifo_rd[head];
   assign sel_data      = sel_alu ? bus.alu_data : fifo_data[head];

   assign clr      = bus.regwrite && wb_lsu;
   assign set_rsv  = bus.rsv_valid && bus.rsv_rd != 5'd0;
   assign set_mask = set_rsv ? 32'd1 << bus.rsv_rd : 32'd0;
   assign clr_mask = clr ? 32'd1 << bus.write_reg : 32'd0;
   assign err      = (set_rsv && bus.pending[bus.rsv_rd] && !(clr && bus.write_reg == bus.rsv_rd))
                   || (clr && !bus.pending[bus.write_reg]);
   assign bus.busy_rs1 = bus.pending[bus.chk_rs1];
   assign bus.busy_rs2 = bus.pending[bus.chk_rs2];

   // LSU result storage, written at the tail on every accepted push
   always_ff @(posedge clock)
      if (push) begin
         fifo_rd[tail]   <= bus.lsu_rd;
         fifo_data[tail] <= bus.lsu_data;
      end

   // FIFO pointers and occupancy; push and pop may happen together
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= (tail == PW'(LSU_DEPTH - 1)) ? '0 : tail + 1'b1;
         if (pop) head <= (head == PW'(LSU_DEPTH - 1)) ? '0 : head + 1'b1;
         count <= count + 3'(push) - 3'(pop);
      end

   // register the selected result; x0 results are consumed without a write
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         bus.write_reg  <= '0;
         bus.write_data <= '0;
         bus.regwrite   <= 1'b0;
         wb_lsu         <= 1'b0;
      end else begin
         bus.write_reg  <= sel_rd;
         bus.write_data <= sel_data;
         bus.regwrite   <= sel && sel_rd != 5'd0;
         wb_lsu         <= pop;
      end

   // pending bits: set on reserve, clear on LSU writeback, set wins on a same-edge collision
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         bus.pending <= '0;
         bus.sb_err  <= 1'b0;
      end else begin
         bus.pending <= (bus.pending & ~clr_mask) | set_mask;
         bus.sb_err  <= bus.sb_err || err;
      end
endmodule
